// File: rtl/accum_drain_pkg.sv
// ----------------------------------------------------------------------------
// accum_drain_pkg
//   Shared parameters, state type and the lane shift/saturate helper used by
//   the accumulation drain paths.
//   Contents:
//     BATCH, RES_W     : lanes per accum_buf entry and accumulator lane width
//     DATA_W_DEF       : signed output lane width after saturation
//     DEPTH_DEF etc.   : default drain-engine geometry
//     drain_state_t    : drain FSM states
//     sat_shift()      : arithmetic right shift then saturate RES_W -> DATA_W
// ----------------------------------------------------------------------------
package accum_drain_pkg;

  localparam int BATCH      = 4;
  localparam int RES_W      = 32;
  localparam int DATA_W_DEF = 16;

  localparam int DEPTH_DEF  = 256;
  localparam int RD_LAT_DEF = 2;
  localparam int FIFO_D_DEF = 4;
  localparam int SHIFT_W    = 5;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    FLUSH,
    DONE
  } drain_state_t;

  // Saturation limits expressed at accumulator width so the compare is exact.
  localparam logic signed [RES_W-1:0] SAT_MAX =
    {{(RES_W-DATA_W_DEF+1){1'b0}}, {(DATA_W_DEF-1){1'b1}}};
  localparam logic signed [RES_W-1:0] SAT_MIN =
    {{(RES_W-DATA_W_DEF+1){1'b1}}, {(DATA_W_DEF-1){1'b0}}};

  // Floor division by 2^sh (arithmetic shift), then clamp to the signed
  // DATA_W_DEF range.
  function automatic logic signed [DATA_W_DEF-1:0] sat_shift(
    input logic signed [RES_W-1:0] x,
    input logic [SHIFT_W-1:0]      sh
  );
    logic signed [RES_W-1:0] y;
    y = x >>> sh;
    if (y > SAT_MAX) begin
      return SAT_MAX[DATA_W_DEF-1:0];
    end else if (y < SAT_MIN) begin
      return SAT_MIN[DATA_W_DEF-1:0];
    end
    return y[DATA_W_DEF-1:0];
  endfunction

endpackage

// File: rtl/accum_drain_if.sv
// ----------------------------------------------------------------------------
// accum_drain_if
//   Bus bundle of the drain engine: the accum_buf read port and the outgoing
//   valid/ready beat stream.
//   Signals:
//     rd_addr   : read address toward accum_buf
//     rd_data   : BATCH signed RES_W lanes returned by accum_buf
//     out_valid : beat valid
//     out_ready : downstream accept
//     out_data  : BATCH saturated DATA_W lanes, lane i at [i*DATA_W +: DATA_W]
//     out_last  : marks the final beat of a drain
//   Modports: master = drain engine, slave = buffer/downstream side.
// ----------------------------------------------------------------------------
interface accum_drain_if
  import accum_drain_pkg::*;
#(
  parameter int ADDR_W = 8
) ();

  logic [ADDR_W-1:0]           rd_addr;
  logic [BATCH*RES_W-1:0]      rd_data;
  logic                        out_valid;
  logic                        out_ready;
  logic [BATCH*DATA_W_DEF-1:0] out_data;
  logic                        out_last;

  modport master (
    output rd_addr,
    input  rd_data,
    output out_valid,
    output out_data,
    output out_last,
    input  out_ready
  );

  modport slave (
    input  rd_addr,
    output rd_data,
    input  out_valid,
    input  out_data,
    input  out_last,
    output out_ready
  );

endinterface

// File: rtl/accum_drain_fifo.sv
// ----------------------------------------------------------------------------
// accum_drain_fifo
//   Small synchronous show-ahead FIFO used as the output skid buffer of the
//   drain engine. The head entry is always visible on pop_data.
//   Ports:
//     clk, rst   : clock, synchronous active-high reset (clears contents)
//     push       : write push_data (accepted when not full, or full + pop)
//     push_data  : entry to store
//     pop        : consume the head entry (ignored when empty)
//     pop_data   : current head entry
//     empty      : no entries stored
//     count      : number of stored entries, 0..DEPTH
// ----------------------------------------------------------------------------
module accum_drain_fifo #(
  parameter  int WIDTH = 65,
  parameter  int DEPTH = 4,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             full;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] bump(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign empty    = (cnt_q == '0);
  assign full     = (cnt_q == CNT_W'(DEPTH));
  assign count    = cnt_q;
  assign pop_data = mem_q[rd_ptr_q];

  // A push into a full FIFO is accepted only when the head leaves this cycle.
  assign do_push = push && (!full || pop);
  assign do_pop  = pop && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_push) begin
      wr_ptr_d = bump(wr_ptr_q);
    end
    if (do_pop) begin
      rd_ptr_d = bump(rd_ptr_q);
    end
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= push_data;
      end
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/accum_drain.sv
// ----------------------------------------------------------------------------
// accum_drain
//   Read-side drain engine for accum_buf. On start it sweeps addresses
//   0..len-1, tags the returning read data, shifts/saturates each lane and
//   streams the results over valid/ready. Reads are only issued while the
//   skid FIFO has room for every read still in flight, so back-pressure never
//   loses or duplicates an entry.
//   Ports:
//     clk, rst  : clock, synchronous active-high reset (aborts a drain)
//     start     : one-cycle pulse, begins a drain (ignored unless idle)
//     len       : entries to drain, 0..DEPTH, sampled on start
//     shift     : arithmetic right shift per lane, sampled on start
//     busy      : drain in progress (READ/FLUSH)
//     done      : one-cycle pulse when the drain completes
//     bus       : accum_buf read port + output beat stream (master side)
// ----------------------------------------------------------------------------
module accum_drain
  import accum_drain_pkg::*;
#(
  parameter int DEPTH  = DEPTH_DEF,
  parameter int ADDR_W = $clog2(DEPTH),
  parameter int RD_LAT = RD_LAT_DEF,
  parameter int FIFO_D = FIFO_D_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [ADDR_W:0]    len,
  input  logic [SHIFT_W-1:0] shift,
  output logic               busy,
  output logic               done,
  accum_drain_if.master      bus
);

  localparam int DATA_W  = DATA_W_DEF;
  localparam int ENTRY_W = BATCH * DATA_W + 1;
  localparam int FCNT_W  = $clog2(FIFO_D + 1);
  localparam int CRED_W  = $clog2(FIFO_D + RD_LAT + 1) + 1;

  drain_state_t       state_q, state_d;
  logic [ADDR_W:0]    len_q, len_d;
  logic [SHIFT_W-1:0] shift_q, shift_d;
  logic [ADDR_W:0]    issue_cnt_q, issue_cnt_d;
  logic [ADDR_W-1:0]  rd_addr_q, rd_addr_d;
  // tag_q[k] marks a read issued k+1 cycles ago; last_q rides alongside it.
  logic [RD_LAT-1:0]  tag_q, tag_d;
  logic [RD_LAT-1:0]  last_q, last_d;

  logic [CRED_W-1:0]       in_flight;
  logic                    credit_ok;
  logic                    issue;
  logic                    issue_last;
  logic                    flush_ok;
  logic                    push;
  logic                    pop;
  logic [BATCH*DATA_W-1:0] lanes;
  logic [ENTRY_W-1:0]      fifo_out;
  logic                    fifo_empty;
  logic [FCNT_W-1:0]       fifo_cnt;

  always_comb begin
    in_flight = '0;
    for (int i = 0; i < RD_LAT; i++) begin
      in_flight = in_flight + CRED_W'(tag_q[i]);
    end
  end

  // Every outstanding read must already own a FIFO slot when it lands.
  assign credit_ok  = (in_flight + CRED_W'(fifo_cnt)) < CRED_W'(FIFO_D);
  assign issue_last = (issue_cnt_q == len_q - (ADDR_W+1)'(1));
  assign pop        = bus.out_valid && bus.out_ready;

  // Exit FLUSH in the same cycle the final beat is accepted; with nothing in
  // flight no push can race the last pop.
  assign flush_ok = (in_flight == '0) &&
                    ((fifo_cnt == '0) || ((fifo_cnt == FCNT_W'(1)) && pop));

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    shift_d     = shift_q;
    issue_cnt_d = issue_cnt_q;
    rd_addr_d   = rd_addr_q;
    issue       = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          if (len == '0) begin
            state_d = DONE;
          end else begin
            len_d       = len;
            shift_d     = shift;
            issue_cnt_d = '0;
            state_d     = READ;
          end
        end
      end
      READ: begin
        busy = 1'b1;
        if (credit_ok) begin
          issue       = 1'b1;
          rd_addr_d   = issue_cnt_q[ADDR_W-1:0];
          issue_cnt_d = issue_cnt_q + (ADDR_W+1)'(1);
          if (issue_last) begin
            state_d = FLUSH;
          end
        end
      end
      FLUSH: begin
        busy = 1'b1;
        if (flush_ok) begin
          state_d = DONE;
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    tag_d     = '0;
    last_d    = '0;
    tag_d[0]  = issue;
    last_d[0] = issue && issue_last;
    for (int i = 1; i < RD_LAT; i++) begin
      tag_d[i]  = tag_q[i-1];
      last_d[i] = last_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      len_q       <= '0;
      shift_q     <= '0;
      issue_cnt_q <= '0;
      rd_addr_q   <= '0;
      tag_q       <= '0;
      last_q      <= '0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      shift_q     <= shift_d;
      issue_cnt_q <= issue_cnt_d;
      rd_addr_q   <= rd_addr_d;
      tag_q       <= tag_d;
      last_q      <= last_d;
    end
  end

  // Returning data is converted and pushed in the cycle its tag matures.
  assign push = tag_q[RD_LAT-1];

  for (genvar gi = 0; gi < BATCH; gi++) begin : g_lane
    assign lanes[gi*DATA_W +: DATA_W] =
      sat_shift(bus.rd_data[gi*RES_W +: RES_W], shift_q);
  end

  accum_drain_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_D)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data ({last_q[RD_LAT-1], lanes}),
    .pop       (pop),
    .pop_data  (fifo_out),
    .empty     (fifo_empty),
    .count     (fifo_cnt)
  );

  assign bus.rd_addr   = rd_addr_q;
  assign bus.out_valid = !fifo_empty;
  assign bus.out_data  = fifo_out[BATCH*DATA_W-1:0];
  assign bus.out_last  = fifo_out[ENTRY_W-1];

endmodule
